// File: rtl/mem_arb16.sv
// Two-port (A = stack engine, B = core data) arbiter in front of a single-port
// synchronous RAM with one-cycle read latency and a saturating contention counter.
module mem_arb16 #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        a_req,
  input  logic        a_we,
  input  logic [15:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_gnt,
  output logic [15:0] a_rdata,
  output logic        a_rvalid,

  input  logic        b_req,
  input  logic        b_we,
  input  logic [15:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_gnt,
  output logic [15:0] b_rdata,
  output logic        b_rvalid,

  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,

  output logic [15:0] conflict_cnt
);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  port_e       last_gnt_q, last_gnt_d;
  logic        a_rd_q, a_rd_d;
  logic        b_rd_q, b_rd_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  logic        contention;
  logic        a_win;
  logic        b_win;

  // Grant decision is purely combinational; reset blocks any grant.
  always_comb begin
    contention = a_req & b_req;
    a_win      = 1'b0;
    b_win      = 1'b0;
    if (!rst) begin
      if (contention) begin
        if ((RR_EN != 0) && (last_gnt_q == PORT_A)) begin
          b_win = 1'b1;
        end else begin
          a_win = 1'b1;
        end
      end else begin
        a_win = a_req;
        b_win = b_req;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    if (a_win) begin
      mem_we    = a_we;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (b_win) begin
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  always_comb begin
    last_gnt_d     = last_gnt_q;
    a_rd_d         = a_win & ~a_we;
    b_rd_d         = b_win & ~b_we;
    conflict_cnt_d = conflict_cnt_q;
    if (a_win) begin
      last_gnt_d = PORT_A;
    end else if (b_win) begin
      last_gnt_d = PORT_B;
    end
    if (contention && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  // Reset leaves last_gnt at B so that A wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q     <= PORT_B;
      a_rd_q         <= 1'b0;
      b_rd_q         <= 1'b0;
      conflict_cnt_q <= 16'h0000;
    end else begin
      last_gnt_q     <= last_gnt_d;
      a_rd_q         <= a_rd_d;
      b_rd_q         <= b_rd_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // A return still pending while reset is asserted is dropped, not delivered.
  assign a_gnt        = a_win;
  assign b_gnt        = b_win;
  assign a_rvalid     = a_rd_q & ~rst;
  assign b_rvalid     = b_rd_q & ~rst;
  assign a_rdata      = mem_rdata;
  assign b_rdata      = mem_rdata;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_mem_arb16.sv
// Bench for mem_arb16: round-robin and fixed-priority instances share stimulus,
// each with its own RAM, checked against a transaction-level model.
module tb_mem_arb16;

  logic        clk;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;

  logic [1:0]  a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, mem_we_o;
  logic [15:0] a_rdata_o [2];
  logic [15:0] b_rdata_o [2];
  logic [15:0] mem_addr_o [2];
  logic [15:0] mem_wdata_o [2];
  logic [15:0] conflict_cnt_o [2];
  bit   [15:0] rd_q [2];
  bit   [15:0] ram0 [65536];
  bit   [15:0] ram1 [65536];

  int checks;
  int failures;

  typedef struct {
    bit          rst;
    bit          a_req;
    bit          a_we;
    logic [15:0] a_addr;
    logic [15:0] a_wdata;
    bit          b_req;
    bit          b_we;
    logic [15:0] b_addr;
    logic [15:0] b_wdata;
  } cyc_t;

  typedef struct {
    cyc_t        in;
    bit          ga;
    bit          gb;
    bit          mwe;
    logic [15:0] maddr;
    bit          rva;
    bit          rvb;
    logic [15:0] rdata;
    logic [15:0] cnt;
  } vec_t;

  // Model state, index 0 = round-robin instance, 1 = fixed priority.
  bit          m_last_b [2];
  int          m_cnt [2];
  bit          m_pa [2];
  bit          m_pb [2];
  logic [15:0] m_pdata;
  bit   [15:0] ref_mem [65536];
  bit          last_ga, last_gb;

  mem_arb16 #(.RR_EN(1)) dut_rr (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt_o[0]), .a_rdata(a_rdata_o[0]), .a_rvalid(a_rvalid_o[0]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt_o[0]), .b_rdata(b_rdata_o[0]), .b_rvalid(b_rvalid_o[0]),
    .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]), .mem_wdata(mem_wdata_o[0]),
    .mem_rdata(rd_q[0]), .conflict_cnt(conflict_cnt_o[0])
  );

  mem_arb16 #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt_o[1]), .a_rdata(a_rdata_o[1]), .a_rvalid(a_rvalid_o[1]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt_o[1]), .b_rdata(b_rdata_o[1]), .b_rvalid(b_rvalid_o[1]),
    .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]), .mem_wdata(mem_wdata_o[1]),
    .mem_rdata(rd_q[1]), .conflict_cnt(conflict_cnt_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAMs with read-old-data behaviour.
  always @(posedge clk) begin
    rd_q[0] <= ram0[mem_addr_o[0]];
    if (mem_we_o[0]) ram0[mem_addr_o[0]] <= mem_wdata_o[0];
    rd_q[1] <= ram1[mem_addr_o[1]];
    if (mem_we_o[1]) ram1[mem_addr_o[1]] <= mem_wdata_o[1];
  end

  function automatic cyc_t cyc(bit r, bit ar, bit aw, logic [15:0] aa, logic [15:0] ad,
                               bit br, bit bw, logic [15:0] ba, logic [15:0] bd);
    cyc_t c;
    c.rst = r; c.a_req = ar; c.a_we = aw; c.a_addr = aa; c.a_wdata = ad;
    c.b_req = br; c.b_we = bw; c.b_addr = ba; c.b_wdata = bd;
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input cyc_t c);
    rst = c.rst;
    a_req = c.a_req; a_we = c.a_we; a_addr = c.a_addr; a_wdata = c.a_wdata;
    b_req = c.b_req; b_we = c.b_we; b_addr = c.b_addr; b_wdata = c.b_wdata;
    #3;
  endtask

  // Compare both instances against the model for the current cycle, then clock.
  task automatic modelStep(input string tag);
    bit ga [2];
    bit gb [2];
    bit rr;
    bit exp_we;
    logic [15:0] exp_addr, exp_wdata;
    for (int k = 0; k < 2; k++) begin
      rr = (k == 0);
      ga[k] = 1'b0;
      gb[k] = 1'b0;
      if (!rst) begin
        if (a_req && b_req) begin
          if (rr && !m_last_b[k]) gb[k] = 1'b1;
          else ga[k] = 1'b1;
        end else begin
          ga[k] = a_req;
          gb[k] = b_req;
        end
      end
      exp_we    = ga[k] ? a_we    : (gb[k] ? b_we    : 1'b0);
      exp_addr  = ga[k] ? a_addr  : (gb[k] ? b_addr  : 16'h0);
      exp_wdata = ga[k] ? a_wdata : (gb[k] ? b_wdata : 16'h0);
      checkOutput($sformatf("%s i%0d a_gnt", tag, k), 32'(a_gnt_o[k]), 32'(ga[k]));
      checkOutput($sformatf("%s i%0d b_gnt", tag, k), 32'(b_gnt_o[k]), 32'(gb[k]));
      checkOutput($sformatf("%s i%0d mem_we", tag, k), 32'(mem_we_o[k]), 32'(exp_we));
      checkOutput($sformatf("%s i%0d mem_addr", tag, k), 32'(mem_addr_o[k]), 32'(exp_addr));
      checkOutput($sformatf("%s i%0d mem_wdata", tag, k), 32'(mem_wdata_o[k]), 32'(exp_wdata));
      checkOutput($sformatf("%s i%0d a_rvalid", tag, k), 32'(a_rvalid_o[k]), 32'(m_pa[k] && !rst));
      checkOutput($sformatf("%s i%0d b_rvalid", tag, k), 32'(b_rvalid_o[k]), 32'(m_pb[k] && !rst));
      checkOutput($sformatf("%s i%0d conflict_cnt", tag, k), 32'(conflict_cnt_o[k]), 32'(m_cnt[k]));
      if (k == 0 && !rst && (m_pa[0] || m_pb[0])) begin
        checkOutput($sformatf("%s a_rdata", tag), 32'(a_rdata_o[0]), 32'(m_pdata));
        checkOutput($sformatf("%s b_rdata", tag), 32'(b_rdata_o[0]), 32'(m_pdata));
      end
    end
    last_ga = ga[0];
    last_gb = gb[0];
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_last_b[k] = 1'b1;
        m_cnt[k]    = 0;
        m_pa[k]     = 1'b0;
        m_pb[k]     = 1'b0;
      end else begin
        if (ga[k]) m_last_b[k] = 1'b0;
        if (gb[k]) m_last_b[k] = 1'b1;
        if (a_req && b_req) m_cnt[k] = (m_cnt[k] < 65535) ? m_cnt[k] + 1 : 65535;
        m_pa[k] = ga[k] && !a_we;
        m_pb[k] = gb[k] && !b_we;
        if (k == 0) begin
          if (ga[0]) begin
            if (!a_we) m_pdata = ref_mem[a_addr];
            else ref_mem[a_addr] = a_wdata;
          end else if (gb[0]) begin
            if (!b_we) m_pdata = ref_mem[b_addr];
            else ref_mem[b_addr] = b_wdata;
          end
        end
      end
    end
  endtask

  task automatic resyncReset();
    applyStimulus(cyc(1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0));
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_last_b[k] = 1'b1;
      m_cnt[k]    = 0;
      m_pa[k]     = 1'b0;
      m_pb[k]     = 1'b0;
    end
  endtask

  initial begin
    vec_t tbl [12];
    cyc_t idle;
    cyc_t c;
    string tag;
    checks   = 0;
    failures = 0;
    idle = cyc(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);

    tbl[0]  = '{cyc(1, 1, 1, 16'h0010, 16'hAAAA, 1, 1, 16'h0020, 16'h1234), 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'd0};
    tbl[1]  = '{cyc(0, 1, 1, 16'h0010, 16'hAAAA, 0, 0, 16'h0000, 16'h0000), 1, 0, 1, 16'h0010, 0, 0, 16'h0000, 16'd0};
    tbl[2]  = '{cyc(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0020, 16'h1234), 0, 1, 1, 16'h0020, 0, 0, 16'h0000, 16'd0};
    tbl[3]  = '{cyc(0, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000), 1, 0, 0, 16'h0010, 0, 0, 16'h0000, 16'd0};
    tbl[4]  = '{idle,                                                       0, 0, 0, 16'h0000, 1, 0, 16'hAAAA, 16'd0};
    tbl[5]  = '{cyc(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000), 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'd0};
    tbl[6]  = '{cyc(0, 1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0020, 16'h0000), 1, 0, 0, 16'h0010, 0, 0, 16'h0000, 16'd0};
    tbl[7]  = '{cyc(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0020, 16'h0000), 0, 1, 0, 16'h0020, 1, 0, 16'hAAAA, 16'd1};
    tbl[8]  = '{idle,                                                       0, 0, 0, 16'h0000, 0, 1, 16'h1234, 16'd1};
    tbl[9]  = '{cyc(0, 1, 1, 16'h0030, 16'h5555, 1, 0, 16'h0030, 16'h0000), 1, 0, 1, 16'h0030, 0, 0, 16'h0000, 16'd1};
    tbl[10] = '{cyc(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0030, 16'h0000), 0, 1, 0, 16'h0030, 0, 0, 16'h0000, 16'd2};
    tbl[11] = '{idle,                                                       0, 0, 0, 16'h0000, 0, 1, 16'h5555, 16'd2};

    resyncReset();

    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].in);
      tag = $sformatf("vec%0d", i);
      checkOutput({tag, " a_gnt"}, 32'(a_gnt_o[0]), 32'(tbl[i].ga));
      checkOutput({tag, " b_gnt"}, 32'(b_gnt_o[0]), 32'(tbl[i].gb));
      checkOutput({tag, " mem_we"}, 32'(mem_we_o[0]), 32'(tbl[i].mwe));
      checkOutput({tag, " mem_addr"}, 32'(mem_addr_o[0]), 32'(tbl[i].maddr));
      checkOutput({tag, " a_rvalid"}, 32'(a_rvalid_o[0]), 32'(tbl[i].rva));
      checkOutput({tag, " b_rvalid"}, 32'(b_rvalid_o[0]), 32'(tbl[i].rvb));
      checkOutput({tag, " conflict_cnt"}, 32'(conflict_cnt_o[0]), 32'(tbl[i].cnt));
      if (tbl[i].rva || tbl[i].rvb) begin
        checkOutput({tag, " rdata"}, 32'(a_rdata_o[0]), 32'(tbl[i].rdata));
      end
      modelStep(tag);
    end

    // Sustained write contention: RR alternates, fixed priority starves B.
    applyStimulus(cyc(1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0));
    modelStep("ctn_rst");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(cyc(0, 1, 1, 16'h0050, 16'(i), 1, 1, 16'h0060, 16'(16'h100 + i)));
      checkOutput($sformatf("ctn%0d rr a_gnt", i), 32'(a_gnt_o[0]), 32'(i % 2 == 0));
      checkOutput($sformatf("ctn%0d rr b_gnt", i), 32'(b_gnt_o[0]), 32'(i % 2 == 1));
      checkOutput($sformatf("ctn%0d fp a_gnt", i), 32'(a_gnt_o[1]), 32'd1);
      checkOutput($sformatf("ctn%0d fp b_gnt", i), 32'(b_gnt_o[1]), 32'd0);
      checkOutput($sformatf("ctn%0d cnt", i), 32'(conflict_cnt_o[0]), 32'(i));
      modelStep($sformatf("ctn%0d", i));
    end
    applyStimulus(idle);
    checkOutput("ctn_end rr cnt", 32'(conflict_cnt_o[0]), 32'd4);
    checkOutput("ctn_end fp cnt", 32'(conflict_cnt_o[1]), 32'd4);
    modelStep("ctn_end");

    // Reset arriving while a read is in flight.
    applyStimulus(cyc(0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0));
    checkOutput("rif a_gnt", 32'(a_gnt_o[0]), 32'd1);
    modelStep("rif_rd");
    applyStimulus(cyc(1, 1, 1, 16'h0070, 16'h7777, 1, 0, 16'h0010, 16'h0));
    checkOutput("rif a_rvalid in rst", 32'(a_rvalid_o[0]), 32'd0);
    checkOutput("rif mem_we in rst", 32'(mem_we_o[0]), 32'd0);
    checkOutput("rif a_gnt in rst", 32'(a_gnt_o[0]), 32'd0);
    modelStep("rif_rst");
    applyStimulus(idle);
    checkOutput("rif a_rvalid after", 32'(a_rvalid_o[0]), 32'd0);
    checkOutput("rif cnt after", 32'(conflict_cnt_o[0]), 32'd0);
    modelStep("rif_after");

    // Randomized traffic; an ungranted request is held unchanged.
    c = idle;
    for (int n = 0; n < 400; n++) begin
      c.rst = ($urandom_range(0, 49) == 0);
      if (!(c.a_req && !last_ga)) begin
        c.a_req   = ($urandom_range(0, 99) < 60);
        c.a_we    = 1'($urandom);
        c.a_addr  = {12'h0, 4'($urandom)};
        c.a_wdata = 16'($urandom);
      end
      if (!(c.b_req && !last_gb)) begin
        c.b_req   = ($urandom_range(0, 99) < 60);
        c.b_we    = 1'($urandom);
        c.b_addr  = {12'h0, 4'($urandom)};
        c.b_wdata = 16'($urandom);
      end
      applyStimulus(c);
      modelStep($sformatf("rnd%0d", n));
    end

    // Saturation: hold both reads for more than 2^16 contended cycles.
    resyncReset();
    applyStimulus(cyc(0, 1, 0, 16'h0001, 16'h0, 1, 0, 16'h0002, 16'h0));
    repeat (65534) @(posedge clk);
    #1;
    checkOutput("sat cnt 65534", 32'(conflict_cnt_o[0]), 32'h0000FFFE);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("sat rr cnt 65536", 32'(conflict_cnt_o[0]), 32'h0000FFFF);
    checkOutput("sat fp cnt 65536", 32'(conflict_cnt_o[1]), 32'h0000FFFF);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("sat cnt hold", 32'(conflict_cnt_o[0]), 32'h0000FFFF);
    resyncReset();
    applyStimulus(idle);
    modelStep("post_sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arb16.md
MEM_ARB16 -- requirements
Module: mem_arb16

Interface
REQ-001 The module SHALL have parameter RR_EN, default 1, meaning 1 = round-robin on contention and 0 = fixed priority to port A.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a_req  input  1  port A (stack engine) access request, held until granted.
REQ-005 a_we  input  1  port A write (1) / read (0).
REQ-006 a_addr  input  16  port A word address.
REQ-007 a_wdata  input  16  port A write data.
REQ-008 a_gnt  output  1  port A access accepted this cycle.
REQ-009 a_rdata  output  16  port A read data, meaningful only when a_rvalid=1.
REQ-010 a_rvalid  output  1  single-cycle pulse marking port A read return.
REQ-011 b_req, b_we, b_addr[16], b_wdata[16], b_gnt, b_rdata[16], b_rvalid SHALL be port B (core data port), identical in direction, width and meaning to port A.
REQ-012 mem_we  output  1  RAM write enable.
REQ-013 mem_addr  output  16  RAM address.
REQ-014 mem_wdata  output  16  RAM write data.
REQ-015 mem_rdata  input  16  RAM read data, one cycle after address (sync read, read-old-data on same-address write).
REQ-016 conflict_cnt  output  16  saturating count of contention cycles.

Function
REQ-017 Grant SHALL be combinational in the request cycle: at most one of a_gnt/b_gnt is 1; a_gnt=1 only if a_req=1; b_gnt=1 only if b_req=1.
REQ-018 Single requester SHALL be granted in the same cycle.
REQ-019 Both requesting with RR_EN=1: grant the port not in register last_gnt; RR_EN=0: always grant A.
REQ-020 last_gnt SHALL update on every granted cycle to the granted port and hold otherwise.
REQ-021 Granted cycle: mem_we, mem_addr, mem_wdata SHALL equal the winner's we/addr/wdata; no grant: mem_we=0, mem_addr=0, mem_wdata=0.
REQ-022 Granted write SHALL complete in the grant cycle, with no rvalid produced.
REQ-023 Granted read SHALL register a read-owner flag, asserting that port's rvalid for exactly the next cycle, with rdata = mem_rdata in that cycle (1-cycle latency).
REQ-024 a_rdata and b_rdata SHALL both be driven from mem_rdata; a_rvalid and b_rvalid are never 1 together.
REQ-025 Back-to-back reads SHALL be supported: one new grant per cycle with rvalid pulses on consecutive cycles to the respective owners.
REQ-026 Read granted at cycle N of an address written at cycle N SHALL return the old RAM content (RAM behaviour, no forwarding).
REQ-027 A requester not granted SHALL see gnt=0 and hold req/we/addr/wdata; the arbiter keeps no request queue.
REQ-028 conflict_cnt SHALL increment by 1 each cycle a_req=1 and b_req=1 with rst=0, saturating at 16'hFFFF.

Reset
REQ-029 While rst=1: a_gnt=b_gnt=0, mem_we=0, mem_addr=0, mem_wdata=0, regardless of requests.
REQ-030 After a reset edge: a_rvalid=b_rvalid=0, read-owner flags cleared, conflict_cnt=0, last_gnt=B (A wins first tie).
REQ-031 Reset during a read in flight SHALL suppress its rvalid; no return is delivered after reset.

Verification
REQ-032 Reset, then A write 0x0010<-AAAA, A read 0x0010 -> a_gnt same cycle, a_rvalid next cycle with a_rdata=AAAA, b_rvalid=0.
REQ-033 A and B both read (A 0x0010, B 0x0020=1234) same cycle after reset, RR_EN=1 -> cycle 0 a_gnt, cycle 1 b_gnt and a_rvalid (AAAA), cycle 2 b_rvalid (1234), conflict_cnt=1.
REQ-034 Both hold write requests 4 cycles, RR_EN=1 -> grants alternate A,B,A,B, conflict_cnt increments each contended cycle; with RR_EN=0 -> A granted every cycle while B starves.
REQ-035 A writes 0x0030<-5555 while B reads 0x0030 (old 0000) in next cycle vs same-cycle contention -> read issued after the write returns 5555; no read in the write cycle.
REQ-036 A read granted, rst=1 on following edge -> no a_rvalid after reset, conflict_cnt=0, mem_we=0 during reset.
REQ-037 Force 65536 contended cycles -> conflict_cnt stays at FFFF, no wrap.
